mdu_seq_alu: RTL

- Parametrised, handshaked successor to the multicycle core's combinational ALU.
- Executes RV32I/RV64I integer ALU ops plus the full M extension:
  - MUL, MULH, MULHSU, MULHU
  - DIV, DIVU, REM, REMU
- Multiply uses a selectable single-cycle or iterative datapath. Divide uses an iterative radix-2 engine.
- Sits between decode/operand fetch and writeback. Results are held until writeback accepts them.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_divider.sv | 67 ++++++
 rtl/mdu_seq_alu.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the sequential ALU / M-extension unit.
// Holds the op-code and FSM enums plus the op-class helpers.
package mdu_pkg;

  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    SLL    = 5'd2,
    SLT    = 5'd3,
    SLTU   = 5'd4,
    XOR    = 5'd5,
    SRL    = 5'd6,
    SRA    = 5'd7,
    OR     = 5'd8,
    AND    = 5'd9,
    LUIP   = 5'd10,
    AUIPC  = 5'd11,
    MUL    = 5'd12,
    MULH   = 5'd13,
    MULHSU = 5'd14,
    MULHU  = 5'd15,
    DIV    = 5'd16,
    DIVU   = 5'd17,
    REM    = 5'd18,
    REMU   = 5'd19
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_mul(alu_op_e op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic is_div(alu_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring radix-2 unsigned divider, one quotient bit per cycle.
// done is asserted during the last step; quotient/remainder are valid then.
module mdu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic            running;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // quotient/remainder are the result of the current step, so the caller
  // can capture the final answer on the same edge that done is seen.
  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, dvs_q};
    remainder = diff[XLEN-1:0];
    quotient  = {quo_q[XLEN-2:0], 1'b1};
    if (diff[XLEN]) begin
      remainder = shifted[XLEN-1:0];
      quotient  = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign done = running && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  // NOTE: pure datapath registers carry no reset; running gates their use.
  always_ff @(posedge clk) begin
    if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (running) begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/mdu_seq_alu.sv
// Handshaked integer ALU with RV M extension: single-cycle ALU ops,
// single-cycle or shift-add multiply, iterative divide with early-outs.
module mdu_seq_alu
  import mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_ITER = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int PW  = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  alu_op_e         cur_op;
  logic            neg_q;
  logic            neg_r;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] p_hi;
  logic [XLEN-1:0] p_lo;
  logic [XLEN-1:0] mcand;

  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            div_ovf;
  logic            div_early;
  logic            div_start;
  logic            div_done;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] early_res;
  logic [XLEN-1:0] quick_res;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] div_r;
  logic [XLEN-1:0] div_res;
  logic [PW-1:0]   prod_comb;
  logic [PW-1:0]   prod_iter;
  logic [XLEN:0]   mul_sum;

  // Products are formed on magnitudes and negated afterwards, so the
  // single-cycle and iterative paths share the same sign fix-up.
  function automatic logic [XLEN-1:0] mul_pick(alu_op_e o, logic neg, logic [PW-1:0] p);
    logic [PW-1:0] s;
    s = neg ? -p : p;
    return (o == MUL) ? s[XLEN-1:0] : s[PW-1:XLEN];
  endfunction

  assign in_ready = !rst && (state == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign shamt    = src_b[SHW-1:0];

  assign a_neg = (op inside {MULH, MULHSU, DIV, REM}) && src_a[XLEN-1];
  assign b_neg = (op inside {MULH, DIV, REM}) && src_b[XLEN-1];
  assign mag_a = a_neg ? -src_a : src_a;
  assign mag_b = b_neg ? -src_b : src_b;

  assign prod_comb = PW'(mag_a) * PW'(mag_b);
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
  assign prod_iter = {mul_sum, p_lo[XLEN-1:1]};

  assign b_zero    = (src_b == '0);
  assign div_ovf   = (op inside {DIV, REM}) && (src_a == MIN_NEG) && (&src_b);
  assign div_early = b_zero || div_ovf;
  assign div_start = accept && is_div(op) && !div_early;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_res = src_a + src_b;
    case (op)
      SUB:     alu_res = src_a - src_b;
      SLL:     alu_res = src_a << shamt;
      SLT:     alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      SLTU:    alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      XOR:     alu_res = src_a ^ src_b;
      SRL:     alu_res = src_a >> shamt;
      SRA:     alu_res = $unsigned($signed(src_a) >>> shamt);
      OR:      alu_res = src_a | src_b;
      AND:     alu_res = src_a & src_b;
      LUIP:    alu_res = src_b;
      default: alu_res = src_a + src_b;
    endcase
  end

  always_comb begin
    early_res = '0;
    if (b_zero) early_res = (op inside {DIV, DIVU}) ? {XLEN{1'b1}} : src_a;
    else if (op == DIV) early_res = src_a;
  end

  assign quick_res = is_mul(op) ? mul_pick(op, a_neg ^ b_neg, prod_comb) :
                     is_div(op) ? early_res : alu_res;

  assign div_res = (cur_op inside {DIV, DIVU}) ? (neg_q ? -div_q : div_q)
                                               : (neg_r ? -div_r : div_r);

  mdu_divider #(.XLEN(XLEN)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .abort     (flush),
    .start     (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if ((MUL_ITER != 0) && is_mul(op)) begin
              state <= S_MUL;
              busy  <= 1'b1;
            end else if (is_div(op) && !div_early) begin
              state <= S_DIV;
              busy  <= 1'b1;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= quick_res;
            end
          end
        end
        S_MUL: begin
          if (cnt == SHW'(XLEN - 1)) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= mul_pick(cur_op, neg_q, prod_iter);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DIV: begin
          if (div_done) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= div_res;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cur_op <= op;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      p_hi   <= '0;
      p_lo   <= mag_b;
      mcand  <= mag_a;
    end else if (state == S_MUL) begin
      p_hi <= mul_sum[XLEN:1];
      p_lo <= {mul_sum[0], p_lo[XLEN-1:1]};
    end
  end

endmodule
